// File: rtl/serial_shifter.sv
// serial_shifter: byte-wide serial link port. A loaded byte is shifted out
// MSB-first on o_sout while i_sin is shifted into the same register, one bit
// per CLK_DIV system clocks. o_irq pulses for one cycle when a transfer ends.
// Optional macro SERIAL_EXT_CLK_EN adds an externally clocked transfer mode
// (ports i_ext_sel, i_sclk).
module serial_shifter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 512
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_start,
  input  logic                  i_sin,
`ifdef SERIAL_EXT_CLK_EN
  input  logic                  i_ext_sel,
  input  logic                  i_sclk,
`endif
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_sclk,
  output logic                  o_sout,
  output logic                  o_irq
);

  localparam int unsigned H  = CLK_DIV / 2;
  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  busy_q,  busy_d;
  logic                  sclk_q,  sclk_d;
  logic                  sout_q,  sout_d;
  logic                  irq_q,   irq_d;
  logic [BW-1:0]         bit_q,   bit_d;
  logic [CW-1:0]         hcnt_q,  hcnt_d;
  logic                  half_done;

`ifdef SERIAL_EXT_CLK_EN
  logic ext_q, ext_d;
  logic sync1_q, sync2_q, sync3_q;
  logic ext_rise, ext_fall;

  // Two-flop synchronizer for i_sclk plus one delay stage for edge detection
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= i_sclk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign ext_rise = sync2_q & ~sync3_q;
  assign ext_fall = ~sync2_q & sync3_q;
`endif

  assign half_done = (hcnt_q == CW'(H - 1));

  // State and output register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b1;
      sout_q  <= 1'b1;
      irq_q   <= 1'b0;
      bit_q   <= '0;
      hcnt_q  <= '0;
`ifdef SERIAL_EXT_CLK_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      irq_q   <= irq_d;
      bit_q   <= bit_d;
      hcnt_q  <= hcnt_d;
`ifdef SERIAL_EXT_CLK_EN
      ext_q   <= ext_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    sout_d  = sout_q;
    irq_d   = 1'b0;
    bit_d   = bit_q;
    hcnt_d  = hcnt_q;
`ifdef SERIAL_EXT_CLK_EN
    ext_d   = ext_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_we) data_d = i_data;
        if (i_start) begin
          // A write in the same cycle wins, so the first bit comes from i_data
          state_d = S_LOW;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          sout_d  = i_we ? i_data[DATA_WIDTH-1] : data_q[DATA_WIDTH-1];
          hcnt_d  = '0;
`ifdef SERIAL_EXT_CLK_EN
          ext_d   = i_ext_sel;
          if (i_ext_sel) sclk_d = 1'b1;
`endif
        end
      end
      S_LOW: begin
`ifdef SERIAL_EXT_CLK_EN
        // External mode stays in LOW; the synced i_sclk edges pace the bits
        if (ext_q) begin
          if (ext_fall) sout_d = data_q[DATA_WIDTH-1];
          if (ext_rise) begin
            data_d = {data_q[DATA_WIDTH-2:0], i_sin};
            if (bit_q == BW'(DATA_WIDTH - 1)) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              sout_d  = 1'b1;
              irq_d   = 1'b1;
              bit_d   = '0;
              ext_d   = 1'b0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end else
`endif
        if (half_done) begin
          state_d = S_HIGH;
          hcnt_d  = '0;
          sclk_d  = 1'b1;
          data_d  = {data_q[DATA_WIDTH-2:0], i_sin};
          bit_d   = bit_q + BW'(1);
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (half_done) begin
          hcnt_d = '0;
          if (bit_q == BW'(DATA_WIDTH)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            sout_d  = 1'b1;
            irq_d   = 1'b1;
            bit_d   = '0;
          end else begin
            state_d = S_LOW;
            sclk_d  = 1'b0;
            sout_d  = data_q[DATA_WIDTH-1];
          end
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_sclk = sclk_q;
  assign o_sout = sout_q;
  assign o_irq  = irq_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed testbench for serial_shifter with DATA_WIDTH=8, CLK_DIV=4.
// Cycle index c counts rising edges after the start edge T (c=1 is T+1);
// outputs are sampled 1ns after each rising edge.
module tb_serial_shifter;

  logic       clk;
  logic       i_reset_n;
  logic       i_we;
  logic [7:0] i_data;
  logic       i_start;
  logic       i_sin;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_sclk;
  logic       o_sout;
  logic       o_irq;

  logic       loop_en;
  logic       sin_val;
  int         checks;
  int         errors;

  assign i_sin = loop_en ? o_sout : sin_val;

  serial_shifter #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_we      (i_we),
    .i_data    (i_data),
    .i_start   (i_start),
    .i_sin     (i_sin),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_sclk    (o_sclk),
    .o_sout    (o_sout),
    .o_irq     (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer; returns 1ns after edge T+1 with i_we/i_start cleared
  task automatic kick(input logic [7:0] d, input logic we);
    @(negedge clk);
    i_we    = we;
    i_data  = d;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_we    = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b1;
    #3;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++;
    if (o_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", o_sclk); end
    checks++;
    if (o_sout !== 1'b1) begin errors++; $display("FAIL reset_sout got %b want 1", o_sout); end
    checks++;
    if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", o_irq); end
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_loopback();
    logic [7:0] pat;
    int         bitn;
    pat     = 8'hA5;
    loop_en = 1'b1;
    kick(pat, 1'b1);
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick();
      if (c >= 2 && c <= 30 && ((c - 2) % 4) == 0) begin
        bitn = 7 - (c - 2) / 4;
        checks++;
        if (o_sout !== pat[bitn])
          begin errors++; $display("FAIL loop_sout c=%0d got %b want %b", c, o_sout, pat[bitn]); end
      end
      checks++;
      if (o_irq !== (c == 33))
        begin errors++; $display("FAIL loop_irq c=%0d got %b want %b", c, o_irq, (c == 33)); end
      checks++;
      if (o_busy !== (c < 33))
        begin errors++; $display("FAIL loop_busy c=%0d got %b want %b", c, o_busy, (c < 33)); end
      if (c == 33) begin
        checks++;
        if (o_data !== 8'hA5) begin errors++; $display("FAIL loop_data got %h want a5", o_data); end
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_fill();
    int lows;
    int falls;
    logic prev;
    lows    = 0;
    falls   = 0;
    prev    = 1'b1;
    sin_val = 1'b0;
    kick(8'hFF, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      if (o_sclk === 1'b0) lows++;
      if (prev === 1'b1 && o_sclk === 1'b0) falls++;
      prev = o_sclk;
    end
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL fill_data got %h want 00", o_data); end
    checks++;
    if (lows != 16) begin errors++; $display("FAIL fill_low_cycles got %0d want 16", lows); end
    checks++;
    if (falls != 8) begin errors++; $display("FAIL fill_pulses got %0d want 8", falls); end
  endtask

  task automatic test_busy();
    int irqs;
    irqs    = 0;
    loop_en = 1'b1;
    kick(8'hA5, 1'b1);
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) begin
        if (c == 10) begin i_we = 1'b1; i_data = 8'h3C; i_start = 1'b1; end
        tick();
        i_we = 1'b0;
        i_start = 1'b0;
      end
      if (o_irq === 1'b1) begin
        irqs++;
        checks++;
        if (c != 33) begin errors++; $display("FAIL busy_irq_time got %0d want 33", c); end
      end
      if (c == 33) begin
        checks++;
        if (o_data !== 8'hA5) begin errors++; $display("FAIL busy_data got %h want a5", o_data); end
      end
    end
    checks++;
    if (irqs != 1) begin errors++; $display("FAIL busy_irq_count got %0d want 1", irqs); end
    loop_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] pat;
    int         bitn;
    pat = 8'h81;
    @(negedge clk);
    i_we   = 1'b1;
    i_data = 8'h00;
    tick();
    i_we    = 1'b0;
    loop_en = 1'b1;
    kick(pat, 1'b1);
    checks++;
    if (o_sout !== 1'b1) begin errors++; $display("FAIL simul_first_bit got %b want 1", o_sout); end
    for (int c = 2; c <= 33; c++) begin
      tick();
      if (c <= 30 && ((c - 2) % 4) == 0) begin
        bitn = 7 - (c - 2) / 4;
        checks++;
        if (o_sout !== pat[bitn])
          begin errors++; $display("FAIL simul_sout c=%0d got %b want %b", c, o_sout, pat[bitn]); end
      end
    end
    checks++;
    if (o_irq !== 1'b1) begin errors++; $display("FAIL simul_irq got %b want 1", o_irq); end
    checks++;
    if (o_data !== 8'h81) begin errors++; $display("FAIL simul_data got %h want 81", o_data); end
    loop_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  waited;
    logic seen;
    seen    = 1'b0;
    waited  = 0;
    loop_en = 1'b1;
    kick(8'h5A, 1'b1);
    while (!seen && waited < 60) begin
      tick();
      waited++;
      if (o_irq === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_irq_timeout got none want pulse"); end
    kick(8'h5A, 1'b0);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", o_busy); end
    checks++;
    if (o_sout !== 1'b0) begin errors++; $display("FAIL b2b_first_bit got %b want 0", o_sout); end
    repeat (40) tick();
    loop_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int irqs;
    irqs    = 0;
    loop_en = 1'b1;
    kick(8'hA5, 1'b1);
    for (int c = 2; c <= 17; c++) tick();
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", o_busy); end
    checks++;
    if (o_sclk !== 1'b1) begin errors++; $display("FAIL mid_sclk got %b want 1", o_sclk); end
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", o_data); end
    checks++;
    if (o_sout !== 1'b1) begin errors++; $display("FAIL mid_sout got %b want 1", o_sout); end
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_irq === 1'b1) irqs++;
    end
    checks++;
    if (irqs != 0) begin errors++; $display("FAIL mid_no_irq got %0d want 0", irqs); end
    kick(8'h3C, 1'b1);
    for (int c = 2; c <= 33; c++) tick();
    checks++;
    if (o_irq !== 1'b1) begin errors++; $display("FAIL mid_next_irq got %b want 1", o_irq); end
    checks++;
    if (o_data !== 8'h3C) begin errors++; $display("FAIL mid_next_data got %h want 3c", o_data); end
    loop_en = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    loop_en   = 1'b0;
    sin_val   = 1'b0;
    i_we      = 1'b0;
    i_data    = 8'h00;
    i_start   = 1'b0;
    i_reset_n = 1'b1;
    test_reset();
    test_loopback();
    test_fill();
    test_busy();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
